pad_mux_ctrl: RTL and testbench
===============================

PAD_MUX_CTRL -- requirements
Module: pad_mux_ctrl

Interface
REQ-001 Parameter NPADS, 8, number of managed pads (1..8).
REQ-002 Parameter SETTLE, 4, blanking cycles before a select change commits (1..15).
REQ-003 Parameter RST_SEL, 16'h5520, per-pad reset select, 2 bits per pad, pad p at [2p+1:2p].
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  request to change one pad's select.
REQ-007 cfg_pad  in  3  target pad index.
REQ-008 cfg_sel  in  2  new select: 0 ALT (peripheral), 1 GPIO_IN, 2 GPIO_OUT, 3 DIS (hi-Z).
REQ-009 cfg_ready  out  1  high only in IDLE; request accepted on cfg_valid && cfg_ready.
REQ-010 cfg_done  out  1  one-cycle pulse when a request completes.
REQ-011 cfg_err  out  1  one-cycle pulse, coincident with cfg_done, for a rejected request.
REQ-012 sel_o  out  16  current committed select vector.
REQ-013 alt_out / alt_oe  in  NPADS each  peripheral drive data and enable per pad.
REQ-014 alt_in  out  NPADS  pad input routed to peripheral.
REQ-015 gpio_out  in  NPADS  GPIO drive data per pad.
REQ-016 gpio_in  out  NPADS  pad input routed to GPIO.
REQ-017 pad_i / pad_oe  out  NPADS each  drive data and enable to the pad tristate cell.
REQ-018 pad_o  in  NPADS  sampled pad level from the tristate cell.

Function
REQ-019 Pad routing (combinational from committed select): ALT -> pad_i=alt_out, pad_oe=alt_oe; GPIO_IN -> pad_i=0, pad_oe=0; GPIO_OUT -> pad_i=gpio_out, pad_oe=1; DIS -> pad_i=0, pad_oe=0.
REQ-020 alt_in[p]=pad_o[p] when select ALT, else 0; gpio_in[p]=pad_o[p] when GPIO_IN or GPIO_OUT (readback), else 0.
REQ-021 FSM states IDLE, BLANK, COMMIT; handshake in IDLE captures cfg_pad/cfg_sel into holding registers.
REQ-022 IDLE -> BLANK on accept when cfg_pad < NPADS and cfg_sel differs from committed select; counter loads SETTLE-1.
REQ-023 BLANK: counter decrements each cycle; BLANK lasts exactly SETTLE cycles, then -> COMMIT.
REQ-024 In BLANK and COMMIT, target pad forced pad_oe=0, pad_i=0, alt_in=0, gpio_in=0; all other pads unaffected.
REQ-025 COMMIT lasts one cycle: cfg_done=1, select register for target pad written at end of cycle, -> IDLE.
REQ-026 Latency: accept at cycle T, BLANK T+1..T+SETTLE, COMMIT T+SETTLE+1, new routing visible T+SETTLE+2.
REQ-027 Same-select request (cfg_sel equals committed): IDLE -> COMMIT directly, no blanking, cfg_done at T+1, no state change.
REQ-028 Out-of-range cfg_pad (>= NPADS): IDLE -> COMMIT, cfg_done=1 and cfg_err=1 at T+1, no select changes.
REQ-029 cfg_ready=0 in BLANK and COMMIT; cfg_valid held during those states is ignored and not queued; next acceptance earliest in first IDLE cycle.
REQ-030 cfg_pad/cfg_sel changes after acceptance have no effect on the in-flight request.
REQ-031 sel_o bits for pads >= NPADS read 0.

Reset
REQ-032 rst in any state: FSM -> IDLE, counter=0, select register=RST_SEL (pads >= NPADS zero), cfg_done=0, cfg_err=0, cfg_ready=1 on next cycle.
REQ-033 rst during BLANK/COMMIT aborts the request; no cfg_done is issued; target pad reverts to RST_SEL routing after reset.

Verification
REQ-034 Reset default: rst then release -> sel_o=16'h5520; pad2 pad_oe=1, pad_i follows gpio_out[2]; pad4..7 pad_oe=0; cfg_ready=1.
REQ-035 Pad4 GPIO_IN->GPIO_OUT, SETTLE=4: accept at T -> pad_oe[4]=0 T..T+5, cfg_done at T+5, pad_oe[4]=1 from T+6, sel_o[9:8]=2.
REQ-036 Pad0 ALT->ALT: accept at T -> cfg_done at T+1, cfg_err=0, no blanking on pad0, cfg_ready=1 at T+2.
REQ-037 NPADS=6, cfg_pad=7: cfg_done=1 and cfg_err=1 at T+1, sel_o unchanged.
REQ-038 cfg_valid held continuously with two requests: second accepted only in first IDLE cycle after first cfg_done; pads other than target keep toggling alt/gpio data throughout.
REQ-039 rst asserted at T+2 of a pad3 ALT->DIS change: no cfg_done, sel_o=16'h5520, pad3 routes ALT after reset.

Source files
------------

// File: rtl/pad_mux_ctrl.sv
// Pad multiplexer controller: routes each pad to its peripheral, GPIO or hi-Z,
// and sequences select changes through a blanking window before committing.
module pad_mux_ctrl #(
    parameter int          NPADS   = 8,
    parameter int          SETTLE  = 4,
    parameter logic [15:0] RST_SEL = 16'h5520
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [2:0]       cfg_pad,
    input  logic [1:0]       cfg_sel,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [15:0]      sel_o,
    input  logic [NPADS-1:0] alt_out,
    input  logic [NPADS-1:0] alt_oe,
    output logic [NPADS-1:0] alt_in,
    input  logic [NPADS-1:0] gpio_out,
    output logic [NPADS-1:0] gpio_in,
    output logic [NPADS-1:0] pad_i,
    output logic [NPADS-1:0] pad_oe,
    input  logic [NPADS-1:0] pad_o
);

    typedef enum logic [1:0] {IDLE, BLANK, COMMIT} state_t;
    typedef enum logic [1:0] {SEL_ALT, SEL_GPIO_IN, SEL_GPIO_OUT, SEL_DIS} sel_t;

    // Select slots of non-existent pads are held at zero forever.
    localparam logic [15:0] SEL_MASK = 16'((17'd1 << (2 * NPADS)) - 17'd1);
    localparam logic [15:0] SEL_RST  = RST_SEL & SEL_MASK;
    localparam logic [3:0]  NPADS_W  = 4'(NPADS);
    localparam logic [3:0]  CNT_LOAD = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  pad_q, pad_d;
    logic [1:0]  tgt_q, tgt_d;
    logic        chg_q, chg_d;
    logic        err_q, err_d;
    logic [15:0] sel_q, sel_d;
    logic        blank_act;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pad_d   = pad_q;
        tgt_d   = tgt_q;
        chg_d   = chg_q;
        err_d   = err_q;
        sel_d   = sel_q;

        cfg_ready = (state_q == IDLE);
        cfg_done  = (state_q == COMMIT);
        cfg_err   = (state_q == COMMIT) && err_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pad_d = cfg_pad;
                    tgt_d = cfg_sel;
                    err_d = ({1'b0, cfg_pad} >= NPADS_W);
                    chg_d = !err_d && (sel_q[{cfg_pad, 1'b0} +: 2] != cfg_sel);
                    if (chg_d) begin
                        state_d = BLANK;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            BLANK: begin
                if (cnt_q == 4'd0) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            COMMIT: begin
                if (chg_q) begin
                    sel_d[{pad_q, 1'b0} +: 2] = tgt_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pad_q   <= 3'd0;
            tgt_q   <= 2'd0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= SEL_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
            tgt_q   <= tgt_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
        end
    end

    // Only a genuine select change isolates its pad while in flight.
    assign blank_act = chg_q && (state_q != IDLE);
    assign sel_o     = sel_q;

    always_comb begin
        alt_in  = '0;
        gpio_in = '0;
        pad_i   = '0;
        pad_oe  = '0;
        for (int p = 0; p < NPADS; p++) begin
            if (!(blank_act && (pad_q == 3'(p)))) begin
                unique case (sel_t'(sel_q[2*p +: 2]))
                    SEL_ALT: begin
                        pad_i[p]  = alt_out[p];
                        pad_oe[p] = alt_oe[p];
                        alt_in[p] = pad_o[p];
                    end
                    SEL_GPIO_IN: begin
                        gpio_in[p] = pad_o[p];
                    end
                    SEL_GPIO_OUT: begin
                        pad_i[p]   = gpio_out[p];
                        pad_oe[p]  = 1'b1;
                        gpio_in[p] = pad_o[p];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Bench for pad_mux_ctrl: an 8-pad and a 6-pad instance driven by random
// requests, checked against a cycle-level reference model and a scoreboard.
module tb_pad_mux_ctrl;

    localparam int          SETTLE  = 4;
    localparam logic [15:0] RST_SEL = 16'h5520;

    typedef struct {
        int          cycle;
        bit          err;
        logic [15:0] sel;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cfg_valid [2];
    logic [2:0]  cfg_pad   [2];
    logic [1:0]  cfg_sel   [2];
    logic        cfg_ready [2];
    logic        cfg_done  [2];
    logic        cfg_err   [2];
    logic [15:0] sel_o     [2];

    logic [7:0] alt_out, alt_oe, gpio_out, pad_o;
    logic [7:0] alt_in8, gpio_in8, pad_i8, pad_oe8;
    logic [5:0] alt_in6, gpio_in6, pad_i6, pad_oe6;

    pad_mux_ctrl #(.NPADS(8), .SETTLE(SETTLE), .RST_SEL(RST_SEL)) dut8 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid[0]), .cfg_pad(cfg_pad[0]), .cfg_sel(cfg_sel[0]),
        .cfg_ready(cfg_ready[0]), .cfg_done(cfg_done[0]), .cfg_err(cfg_err[0]),
        .sel_o(sel_o[0]),
        .alt_out(alt_out), .alt_oe(alt_oe), .alt_in(alt_in8),
        .gpio_out(gpio_out), .gpio_in(gpio_in8),
        .pad_i(pad_i8), .pad_oe(pad_oe8), .pad_o(pad_o)
    );

    pad_mux_ctrl #(.NPADS(6), .SETTLE(SETTLE), .RST_SEL(RST_SEL)) dut6 (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid[1]), .cfg_pad(cfg_pad[1]), .cfg_sel(cfg_sel[1]),
        .cfg_ready(cfg_ready[1]), .cfg_done(cfg_done[1]), .cfg_err(cfg_err[1]),
        .sel_o(sel_o[1]),
        .alt_out(alt_out[5:0]), .alt_oe(alt_oe[5:0]), .alt_in(alt_in6),
        .gpio_out(gpio_out[5:0]), .gpio_in(gpio_in6),
        .pad_i(pad_i6), .pad_oe(pad_oe6), .pad_o(pad_o[5:0])
    );

    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb_q [2][$];

    // Reference model: committed select per pad plus scheduled blank/commit windows.
    int msel      [2][8];
    int busy_end  [2];
    int blank_pad [2];
    int blank_s   [2];
    int blank_e   [2];
    int pend_cyc  [2];
    int pend_pad  [2];
    int pend_sel  [2];
    bit rst_pend  [2];
    bit live      [2];
    bit accepted  [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d: got 0x%0h, expected 0x%0h",
                     name, k, cyc, act, exp);
        end
    endtask

    function automatic int npads(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic logic [15:0] pack_sel(input int k);
        logic [15:0] v;
        v = '0;
        for (int p = 0; p < 8; p++) v[2*p +: 2] = 2'(msel[k][p]);
        return v;
    endfunction

    function automatic logic [15:0] rst_val(input int k);
        logic [15:0] v;
        v = '0;
        for (int p = 0; p < npads(k); p++) v[2*p +: 2] = RST_SEL[2*p +: 2];
        return v;
    endfunction

    task automatic reset_model(input int k);
        for (int p = 0; p < 8; p++)
            msel[k][p] = (p < npads(k)) ? int'(RST_SEL[2*p +: 2]) : 0;
        busy_end[k]  = -1;
        blank_pad[k] = -1;
        blank_s[k]   = 0;
        blank_e[k]   = -1;
        pend_cyc[k]  = -1;
    endtask

    task automatic accept(input int k);
        int   pad;
        int   sel;
        exp_t e;
        pad = int'(cfg_pad[k]);
        sel = int'(cfg_sel[k]);
        e.sel = pack_sel(k);
        e.err = 1'b0;
        e.cycle = cyc + 1;
        accepted[k] = 1'b1;
        if (pad >= npads(k)) begin
            e.err = 1'b1;
        end else if (msel[k][pad] != sel) begin
            e.cycle = cyc + SETTLE + 1;
            e.sel[2*pad +: 2] = 2'(sel);
            blank_pad[k] = pad;
            blank_s[k]   = cyc + 1;
            blank_e[k]   = cyc + SETTLE + 1;
            pend_cyc[k]  = cyc + SETTLE + 2;
            pend_pad[k]  = pad;
            pend_sel[k]  = sel;
        end
        busy_end[k] = e.cycle;
        sb_q[k].push_back(e);
    endtask

    logic [7:0] e_pi, e_poe, e_ai, e_gi, a_pi, a_poe, a_ai, a_gi;
    bit         blk;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_pend[k]) begin
                reset_model(k);
                rst_pend[k] = 1'b0;
                live[k] = 1'b1;
            end
            if (pend_cyc[k] == cyc) msel[k][pend_pad[k]] = pend_sel[k];
            if (live[k]) begin
                e_pi = '0; e_poe = '0; e_ai = '0; e_gi = '0;
                for (int p = 0; p < npads(k); p++) begin
                    blk = (p == blank_pad[k]) && (cyc >= blank_s[k]) && (cyc <= blank_e[k]);
                    if (!blk) begin
                        case (msel[k][p])
                            0: begin e_pi[p] = alt_out[p]; e_poe[p] = alt_oe[p]; e_ai[p] = pad_o[p]; end
                            1: e_gi[p] = pad_o[p];
                            2: begin e_pi[p] = gpio_out[p]; e_poe[p] = 1'b1; e_gi[p] = pad_o[p]; end
                            default: ;
                        endcase
                    end
                end
                a_pi  = (k == 0) ? pad_i8   : {2'b00, pad_i6};
                a_poe = (k == 0) ? pad_oe8  : {2'b00, pad_oe6};
                a_ai  = (k == 0) ? alt_in8  : {2'b00, alt_in6};
                a_gi  = (k == 0) ? gpio_in8 : {2'b00, gpio_in6};
                check("pad_i",   k, 32'(a_pi),  32'(e_pi));
                check("pad_oe",  k, 32'(a_poe), 32'(e_poe));
                check("alt_in",  k, 32'(a_ai),  32'(e_ai));
                check("gpio_in", k, 32'(a_gi),  32'(e_gi));
                check("cfg_ready", k, 32'(cfg_ready[k]), 32'(cyc > busy_end[k]));
                check("sel_o", k, 32'(sel_o[k]), 32'(pack_sel(k)));
            end
            if (rst) begin
                rst_pend[k] = 1'b1;
                while (sb_q[k].size() > 0 && sb_q[k][sb_q[k].size()-1].cycle > cyc)
                    sb_q[k].delete(sb_q[k].size() - 1);
            end else if (live[k] && cfg_valid[k] && (cyc > busy_end[k])) begin
                accept(k);
            end
        end
    end

    // Monitor: pops the scoreboard whenever a DUT signals completion.
    exp_t        mon_e;
    bit          selchk     [2];
    logic [15:0] selchk_val [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (live[k]) begin
                if (selchk[k]) begin
                    check("sel_after_done", k, 32'(sel_o[k]), 32'(selchk_val[k]));
                    selchk[k] = 1'b0;
                end
                if (cfg_done[k] === 1'b1) begin
                    if (sb_q[k].size() == 0) begin
                        check("unexpected_done", k, 32'(cfg_done[k]), 32'd0);
                    end else begin
                        mon_e = sb_q[k].pop_front();
                        check("done_cycle", k, 32'(cyc), 32'(mon_e.cycle));
                        check("done_err", k, 32'(cfg_err[k]), 32'(mon_e.err));
                        selchk[k] = 1'b1;
                        selchk_val[k] = rst ? rst_val(k) : mon_e.sel;
                    end
                end else begin
                    check("err_without_done", k, 32'(cfg_err[k]), 32'd0);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        alt_out  = 8'($urandom);
        alt_oe   = 8'($urandom);
        gpio_out = 8'($urandom);
        pad_o    = 8'($urandom);
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic req(input int k, input int pad, input int sel, input bit keep);
        cfg_pad[k]   = 3'(pad);
        cfg_sel[k]   = 2'(sel);
        cfg_valid[k] = 1'b1;
        accepted[k]  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (accepted[k]) break;
        end
        check("accept_seen", k, 32'(accepted[k]), 32'd1);
        if (!keep) begin
            cfg_valid[k] = 1'b0;
            cfg_pad[k]   = 3'($urandom);
            cfg_sel[k]   = 2'($urandom);
        end
    endtask

    task automatic directed(input int k);
        req(k, 4, 2, 1'b0);
        req(k, 0, 0, 1'b0);
        req(k, 1, 3, 1'b1);
        req(k, 5, 2, 1'b0);
        req(k, 7, 3, 1'b0);
        req(k, 6, 0, 1'b0);
        req(k, 2, 2, 1'b0);
    endtask

    task automatic random_stream(input int k);
        for (int i = 0; i < 40; i++) begin
            int pad  = int'($urandom_range(0, 7));
            int sel  = int'($urandom_range(0, 3));
            bit keep = ($urandom_range(0, 3) == 0);
            int gap  = int'($urandom_range(0, 2));
            req(k, pad, sel, keep);
            if (!keep) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        cfg_valid[k] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (cyc > busy_end[0] && cyc > busy_end[1]) break;
        end
        check("idle_reached", 0, 32'(cfg_ready[0] & cfg_ready[1]), 32'd1);
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        for (int k = 0; k < 2; k++) begin
            reset_model(k);
            rst_pend[k]  = 1'b0;
            live[k]      = 1'b0;
            accepted[k]  = 1'b0;
            selchk[k]    = 1'b0;
            cfg_valid[k] = 1'b0;
            cfg_pad[k]   = 3'd0;
            cfg_sel[k]   = 2'd0;
        end
        alt_out = '0; alt_oe = '0; gpio_out = '0; pad_o = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_sel_o", 0, 32'(sel_o[0]), 32'h5520);
        check("rst_sel_o", 1, 32'(sel_o[1]), 32'h0520);
        check("rst_pad2_oe", 0, 32'(pad_oe8[2]), 32'd1);
        check("rst_pad2_i", 0, 32'(pad_i8[2]), 32'(gpio_out[2]));
        check("rst_pad7_4_oe", 0, 32'(pad_oe8[7:4]), 32'd0);
        check("rst_ready", 0, 32'(cfg_ready[0]), 32'd1);

        @(posedge clk);
        #1;
        fork
            directed(0);
            directed(1);
        join
        fork
            random_stream(0);
            random_stream(1);
        join
        wait_idle();

        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Pad 3 ALT -> DIS, aborted by reset two cycles after acceptance.
        for (int k = 0; k < 2; k++) begin
            cfg_pad[k]   = 3'd3;
            cfg_sel[k]   = 2'd3;
            cfg_valid[k] = 1'b1;
            accepted[k]  = 1'b0;
        end
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (accepted[0] && accepted[1]) break;
        end
        check("abort_accept", 0, 32'(accepted[0] & accepted[1]), 32'd1);
        cfg_valid[0] = 1'b0;
        cfg_valid[1] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * SETTLE) @(posedge clk);

        @(negedge clk);
        check("abort_sel_o", 0, 32'(sel_o[0]), 32'h5520);
        check("abort_sel_o", 1, 32'(sel_o[1]), 32'h0520);
        check("abort_pad3_oe", 0, 32'(pad_oe8[3]), 32'(alt_oe[3]));
        check("abort_pad3_i", 0, 32'(pad_i8[3]), 32'(alt_out[3]));
        check("sb_empty", 0, 32'(sb_q[0].size()), 32'd0);
        check("sb_empty", 1, 32'(sb_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
